// File: rtl/config_pkg.sv
// Core configuration record serialized by cfg_dump.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned VLEN;
    int unsigned PLEN;
    int unsigned GPLEN;
    bit          RVA;
    bit          RVB;
    bit          RVC;
    bit          RVD;
    bit          RVF;
    bit          RVH;
    bit          RVS;
    bit          RVU;
    bit          RVV;
    bit          RVZCB;
    bit          RVZCMP;
    bit          RVZiCond;
    bit          RVZicntr;
    bit          RVZihpm;
    bit          XF16;
    bit          XF16ALT;
    bit          XF8;
    bit          XFVec;
    bit          CvxifEn;
    bit          MmuPresent;
    bit          DebugEn;
    bit          PerfCounterEn;
    int unsigned NrCommitPorts;
    int unsigned NrWbPorts;
    int unsigned NR_SB_ENTRIES;
    int unsigned NrPMPEntries;
    int unsigned NrLoadBufEntries;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned ICACHE_INDEX_WIDTH;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned DCACHE_SET_ASSOC;
    int unsigned DCACHE_INDEX_WIDTH;
    int unsigned DCACHE_LINE_WIDTH;
    int unsigned InstrTlbEntries;
    int unsigned DataTlbEntries;
    int unsigned SharedTlbDepth;
    bit          UseSharedTlb;
    int unsigned PtLevels;
    logic [63:0] HaltAddress;
    logic [63:0] ExceptionAddress;
    logic [63:0] DmBaseAddress;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

// File: rtl/cfg_dump.sv
// cfg_dump: streams the elaborated core configuration as a sequence of
// 32-bit words over a valid/ready handshake after a start request.
// Optional feature macro CFG_DUMP_CHECKSUM_EN appends an XOR checksum word.
module cfg_dump #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        abort_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic [3:0]  index_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int DATA_W = 32;
`ifdef CFG_DUMP_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd12;
`endif

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_p0, state_nxt;
  logic [3:0]        idx_p0, idx_nxt;
  logic              done_p0, done_nxt;
  logic              stream, xfer;
  logic [DATA_W-1:0] word;

  // Static word map; oversized fields keep only their low bits.
  function automatic logic [DATA_W-1:0] cfg_word(input logic [3:0] i);
    logic [DATA_W-1:0] w;
    w = '0;
    case (i)
      4'd0:  w = 32'hC0F6_0001;
      4'd1:  w = {CVA6Cfg.GPLEN[7:0], CVA6Cfg.PLEN[7:0], CVA6Cfg.VLEN[7:0], CVA6Cfg.XLEN[7:0]};
      4'd2:  w = {10'b0, CVA6Cfg.PerfCounterEn, CVA6Cfg.DebugEn, CVA6Cfg.MmuPresent,
                  CVA6Cfg.CvxifEn, CVA6Cfg.XFVec, CVA6Cfg.XF8, CVA6Cfg.XF16ALT, CVA6Cfg.XF16,
                  CVA6Cfg.RVZihpm, CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond, CVA6Cfg.RVZCMP,
                  CVA6Cfg.RVZCB, CVA6Cfg.RVV, CVA6Cfg.RVU, CVA6Cfg.RVS, CVA6Cfg.RVH,
                  CVA6Cfg.RVF, CVA6Cfg.RVD, CVA6Cfg.RVC, CVA6Cfg.RVB, CVA6Cfg.RVA};
      4'd3:  w = {CVA6Cfg.NrLoadBufEntries[7:0], CVA6Cfg.NrPMPEntries[7:0],
                  CVA6Cfg.NR_SB_ENTRIES[7:0], CVA6Cfg.NrWbPorts[3:0], CVA6Cfg.NrCommitPorts[3:0]};
      4'd4:  w = {CVA6Cfg.ICACHE_LINE_WIDTH[15:0], CVA6Cfg.ICACHE_INDEX_WIDTH[7:0],
                  CVA6Cfg.ICACHE_SET_ASSOC[7:0]};
      4'd5:  w = {CVA6Cfg.DCACHE_LINE_WIDTH[15:0], CVA6Cfg.DCACHE_INDEX_WIDTH[7:0],
                  CVA6Cfg.DCACHE_SET_ASSOC[7:0]};
      4'd6:  w = {CVA6Cfg.PtLevels[3:0], 3'b000, CVA6Cfg.UseSharedTlb,
                  CVA6Cfg.SharedTlbDepth[7:0], CVA6Cfg.DataTlbEntries[7:0],
                  CVA6Cfg.InstrTlbEntries[7:0]};
      4'd7:  w = CVA6Cfg.HaltAddress[31:0];
      4'd8:  w = CVA6Cfg.HaltAddress[63:32];
      4'd9:  w = CVA6Cfg.ExceptionAddress[31:0];
      4'd10: w = CVA6Cfg.ExceptionAddress[63:32];
      4'd11: w = CVA6Cfg.DmBaseAddress[31:0];
      4'd12: w = CVA6Cfg.DmBaseAddress[63:32];
      default: w = '0;
    endcase
    return w;
  endfunction

  assign stream = (state_p0 == STREAM);
  assign xfer   = stream & ready_i;

`ifdef CFG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_p0;

  // Checksum accumulator: cleared at dump start, folds in every transferred map word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_p0 <= '0;
    end else if (state_p0 == IDLE && req_i) begin
      acc_p0 <= '0;
    end else if (xfer && idx_p0 != LAST_IDX) begin
      acc_p0 <= acc_p0 ^ word;
    end
  end

  assign word = (idx_p0 == LAST_IDX) ? acc_p0 : cfg_word(idx_p0);
`else
  assign word = cfg_word(idx_p0);
`endif

  // State, word index and done-pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_p0 <= IDLE;
      idx_p0   <= '0;
      done_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
      done_p0  <= done_nxt;
    end
  end

  // Next-state logic; abort wins over a same-cycle transfer, even the last one.
  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    done_nxt  = 1'b0;
    case (state_p0)
      IDLE: begin
        if (req_i) begin
          state_nxt = STREAM;
          idx_nxt   = '0;
        end
      end
      STREAM: begin
        if (abort_i) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else if (xfer) begin
          if (idx_p0 == LAST_IDX) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx_p0 + 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Outputs decode straight from registers so reset clears them without a clock.
  always_comb begin
    valid_o = stream;
    busy_o  = stream;
    data_o  = stream ? word : '0;
    index_o = stream ? idx_p0 : 4'd0;
    last_o  = stream && (idx_p0 == LAST_IDX);
    done_o  = done_p0;
  end

endmodule

// File: tb/tb_cfg_dump.sv
// Directed testbench for cfg_dump using a hand-computed word table.
module tb_cfg_dump;

  localparam config_pkg::cva6_cfg_t CFG = '{
    XLEN: 64, VLEN: 64, PLEN: 56, GPLEN: 41,
    RVA: 1'b1, RVC: 1'b1, RVD: 1'b1, RVF: 1'b1, RVS: 1'b1, RVU: 1'b1,
    RVZCB: 1'b1, RVZiCond: 1'b1, RVZicntr: 1'b1,
    CvxifEn: 1'b1, MmuPresent: 1'b1, DebugEn: 1'b1,
    NrCommitPorts: 2, NrWbPorts: 32'h13, NR_SB_ENTRIES: 8, NrPMPEntries: 16,
    NrLoadBufEntries: 2,
    ICACHE_SET_ASSOC: 4, ICACHE_INDEX_WIDTH: 12, ICACHE_LINE_WIDTH: 128,
    DCACHE_SET_ASSOC: 8, DCACHE_INDEX_WIDTH: 16, DCACHE_LINE_WIDTH: 32'h10040,
    InstrTlbEntries: 16, DataTlbEntries: 16, SharedTlbDepth: 64,
    UseSharedTlb: 1'b1, PtLevels: 3,
    HaltAddress: 64'h0000_0000_0000_0800,
    ExceptionAddress: 64'h0000_0000_0000_0808,
    DmBaseAddress: 64'h0000_0012_3456_7000,
    default: '0
  };

`ifdef CFG_DUMP_CHECKSUM_EN
  localparam int LAST = 13;
`else
  localparam int LAST = 12;
`endif

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;
  logic        valid, last, busy, done;
  logic [31:0] data;
  logic [3:0]  index;

  int tests = 0;
  int fails = 0;
  vec_t tbl[14];

  cfg_dump #(.CVA6Cfg(CFG)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .abort_i(abort),
    .valid_o(valid), .ready_i(ready), .data_o(data), .index_o(index),
    .last_o(last), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_last"},  32'(last),  32'd0);
    chk({tag, "_data"},  data,       32'd0);
    chk({tag, "_index"}, 32'(index), 32'd0);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] sdata;
    logic [3:0]  sidx;
    bit          stalled, seen_done;
    int          cnt;

    tbl[0]  = '{4'd0,  32'hC0F6_0001};
    tbl[1]  = '{4'd1,  32'h2938_4040};
    tbl[2]  = '{4'd2,  32'h001C_1ADD};
    tbl[3]  = '{4'd3,  32'h0210_0832};
    tbl[4]  = '{4'd4,  32'h0080_0C04};
    tbl[5]  = '{4'd5,  32'h0040_1008};
    tbl[6]  = '{4'd6,  32'h3140_1010};
    tbl[7]  = '{4'd7,  32'h0000_0800};
    tbl[8]  = '{4'd8,  32'h0000_0000};
    tbl[9]  = '{4'd9,  32'h0000_0808};
    tbl[10] = '{4'd10, 32'h0000_0000};
    tbl[11] = '{4'd11, 32'h3456_7000};
    tbl[12] = '{4'd12, 32'h0000_0012};
    x = '0;
    for (int i = 0; i < 13; i++) x = x ^ tbl[i].word;
    tbl[13] = '{4'd13, x};

    // Reset state
    #1 rst = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full dump with ready held high, compared against the table
    chk("idle_valid", 32'(valid), 32'd0);
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i <= LAST; i++) begin
      chk("dump_valid", 32'(valid), 32'd1);
      chk("dump_index", 32'(index), 32'(tbl[i].idx));
      chk("dump_data",  data,       tbl[i].word);
      chk("dump_last",  32'(last),  32'(i == LAST));
      chk("dump_done",  32'(done),  32'd0);
      tick();
    end
    chk("end_valid", 32'(valid), 32'd0);
    chk("end_done",  32'(done),  32'd1);
    chk("end_busy",  32'(busy),  32'd0);
    tick();
    chk("done_width", 32'(done), 32'd0);

    // ready toggling: each word once, in order, stable while stalled
    req = 1'b1;
    tick();
    req = 1'b0;
    cnt = 0;
    stalled = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      if (stalled) begin
        chk("stall_data",  data,       sdata);
        chk("stall_index", 32'(index), 32'(sidx));
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        ready = (c % 2 == 0);
        stalled = 1'b0;
        if (valid && ready) begin
          chk("tog_index", 32'(index), 32'(cnt));
          chk("tog_data",  data, tbl[cnt % 14].word);
          cnt++;
        end else if (valid) begin
          stalled = 1'b1;
          sdata = data;
          sidx = index;
        end
        tick();
      end
    end
    chk("tog_done",  32'(seen_done), 32'd1);
    chk("tog_count", 32'(cnt), 32'(LAST + 1));
    ready = 1'b1;
    tick();

    // Abort at index 5 with a same-cycle transfer
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (5) tick();
    chk("abort_at5_index", 32'(index), 32'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_done",  32'(done),  32'd0);
    tick();
    chk("abort_done2", 32'(done), 32'd0);
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("restart_valid", 32'(valid), 32'd1);
    chk("restart_index", 32'(index), 32'd0);
    chk("restart_data",  data, tbl[0].word);

    // Abort on the last word beats its transfer
    repeat (LAST) tick();
    chk("lastab_last", 32'(last), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("lastab_valid", 32'(valid), 32'd0);
    chk("lastab_done",  32'(done),  32'd0);
    tick();
    chk("lastab_done2", 32'(done), 32'd0);

    // Abort while idle does nothing
    abort = 1'b1;
    tick();
    tick();
    chk("idleab_busy", 32'(busy), 32'd0);
    chk("idleab_done", 32'(done), 32'd0);
    abort = 1'b0;

    // Asynchronous reset at index 7
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (7) tick();
    chk("rst7_index", 32'(index), 32'd7);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("postrst_index", 32'(index), 32'd0);
    chk("postrst_data",  data, tbl[0].word);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // req held high: no mid-stream restart, next dump right after done
    req = 1'b1;
    tick();
    for (int i = 0; i <= LAST; i++) begin
      chk("held_index", 32'(index), 32'(tbl[i].idx));
      chk("held_data",  data, tbl[i].word);
      tick();
    end
    chk("held_done",  32'(done),  32'd1);
    chk("held_valid", 32'(valid), 32'd0);
    tick();
    req = 1'b0;
    chk("held_rest_valid", 32'(valid), 32'd1);
    chk("held_rest_index", 32'(index), 32'd0);
    chk("held_rest_data",  data, tbl[0].word);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_dump.md
CFG_DUMP -- requirements
Module: cfg_dump

Interface
REQ-001 SHALL have parameter CVA6Cfg, type config_pkg::cva6_cfg_t, default config_pkg::cva6_cfg_empty; elaborated core configuration to serialize.
REQ-002 SHALL have input clk_i, 1 bit; the single clock.
REQ-003 SHALL have input rst_i, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have input req_i, 1 bit; start-dump request, sampled in IDLE only.
REQ-005 SHALL have input abort_i, 1 bit; terminate the dump in progress.
REQ-006 SHALL have output valid_o, 1 bit; data_o holds a valid word.
REQ-007 SHALL have input ready_i, 1 bit; consumer accepts the word (transfer = valid_o & ready_i).
REQ-008 SHALL have output data_o, 32 bits; current configuration word.
REQ-009 SHALL have output index_o, 4 bits; word index of data_o.
REQ-010 SHALL have output last_o, 1 bit; data_o is the final word.
REQ-011 SHALL have output busy_o, 1 bit; FSM is not in IDLE.
REQ-012 SHALL have output done_o, 1 bit; one-cycle pulse after the final transfer.

Function
REQ-013 SHALL implement FSM states IDLE and STREAM.
REQ-014 IDLE + req_i=1 -> STREAM next cycle; index=0; valid_o=1 from that cycle.
REQ-015 In STREAM, each transfer SHALL increment index by 1; the following cycle presents the next word, giving zero-bubble throughput of 1 word/cycle.
REQ-016 While valid_o=1 and ready_i=0, data_o, index_o and last_o SHALL hold stable.
REQ-017 The transfer with last_o=1 SHALL move the FSM to IDLE, drop valid_o the next cycle, and pulse done_o=1 for exactly that next cycle.
REQ-018 abort_i=1 in STREAM SHALL move the FSM to IDLE next cycle with valid_o=0 and no done_o; abort takes priority over a same-cycle transfer, including the last one.
REQ-019 req_i in STREAM SHALL be ignored; abort_i in IDLE SHALL have no effect.
REQ-020 Word map, unused bits 0:
- w0 = 0xC0F6_0001.
- w1 = {GPLEN[7:0], PLEN[7:0], VLEN[7:0], XLEN[7:0]}.
- w2 flag bits 0..21 = RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU, RVV, RVZCB, RVZCMP, RVZiCond, RVZicntr, RVZihpm, XF16, XF16ALT, XF8, XFVec, CvxifEn, MmuPresent, DebugEn, PerfCounterEn.
- w3 = {NrLoadBufEntries[7:0], NrPMPEntries[7:0], NR_SB_ENTRIES[7:0], NrWbPorts[3:0], NrCommitPorts[3:0]}.
- w4 = {ICACHE_LINE_WIDTH[15:0], ICACHE_INDEX_WIDTH[7:0], ICACHE_SET_ASSOC[7:0]}.
- w5 = the same layout for DCACHE.
- w6 = {PtLevels[3:0], 3'b0, UseSharedTlb, SharedTlbDepth[7:0], DataTlbEntries[7:0], InstrTlbEntries[7:0]}.
- w7/w8 = HaltAddress low/high.
- w9/w10 = ExceptionAddress low/high.
- w11/w12 = DmBaseAddress low/high.
REQ-021 Fields wider than their slot SHALL be truncated to the low bits; 64-bit addresses are zero-extended from their configured width.

Reset
REQ-022 rst_i=1 SHALL asynchronously force the FSM to IDLE, index=0, checksum accumulator=0, and valid_o=0, done_o=0, busy_o=0, last_o=0, data_o=0, index_o=0, including when asserted mid-dump.
REQ-023 After rst_i deasserts, the first req_i SHALL start a dump at w0.

Configuration
REQ-024 Macro CFG_DUMP_CHECKSUM_EN defined: a 32-bit accumulator SHALL clear on dump start and XOR in each transferred word w0..w12; w13 = accumulator value; last index = 13; 14 words total.
REQ-025 Macro CFG_DUMP_CHECKSUM_EN undefined: no accumulator; last index = 12; 13 words total.

Verification
REQ-026 XLEN=64 config, ready_i=1, req_i pulse -> w0 = 0xC0F60001, w1 = 0x29384040, 13 (or 14) consecutive valid cycles, then done_o for exactly one cycle.
REQ-027 ready_i toggling 1/0 each cycle -> every word seen exactly once, in order, with data_o stable during every stall cycle.
REQ-028 abort_i=1 at index 5 -> valid_o=0 next cycle, no done_o; a new req_i then restarts the dump at w0.
REQ-029 rst_i asserted at index 7 -> all outputs 0 immediately, without waiting for a clock edge.
REQ-030 CFG_DUMP_CHECKSUM_EN defined -> w13 equals the XOR of w0..w12 and last_o=1 only at index 13; undefined -> last_o=1 at index 12.
REQ-031 req_i=1 held throughout a dump -> no restart mid-stream; a new dump starts on the cycle after done_o.
